cpu_control_fsm: RTL
====================

Name: cpu_control_fsm

Overview:
- Instruction-register and control-sequencer stage directly upstream of the ALU datapath.
- Captures a 9-bit instruction from the data input and steps through timing states T0–T3.
- Drives the ALU controls (ain, gin, sub), the register-file load/drive enables, bus source selects and a done strobe.
- Instruction format IR[8:6]=opcode, IR[5:3]=X (destination/first operand), IR[2:0]=Y (source/second operand).

Parameters:
- DATA_W, 16, width of din and the datapath bus.
- IR_W, 9, instruction width; din[IR_W-1:0] is captured.
- NREG, 8, register count; one-hot width of rin/rout.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start request; sampled only in T0.
- din  in  DATA_W  instruction/immediate source.
- irin  out  1  IR load enable (T0 with run).
- rin  out  NREG  one-hot register load enable.
- rout  out  NREG  one-hot register bus-drive enable.
- dinout  out  1  din drives bus (mvi immediate).
- gout  out  1  G register drives bus.
- ain  out  1  ALU A register load.
- gin  out  1  ALU G register load.
- sub  out  1  ALU op select, 1=subtract, 0=add.
- done  out  1  last cycle of the instruction.
- ir  out  IR_W  current instruction register (debug/visibility).

Behaviour:
- State register: T0, T1, T2, T3, encoded 2-bit. IR register IR_W bits. Both update on rising clock.
- Reset, asynchronous: state=T0, IR=0. While reset is high, all control outputs are forced 0, including irin.
- Outputs are combinational decodes of state and IR. The only exception is irin, which also depends on run.
- Outputs not listed for a state are 0.
- T0:
  - irin=run.
  - If run: IR<=din[8:0]; next T1. Otherwise stay in T0, IR unchanged.
- T1, by opcode:
  - 000 mv: rout[Y]=1, rin[X]=1, done=1; next T0.
  - 001 mvi: dinout=1, rin[X]=1, done=1; next T0.
  - 010 add: rout[X]=1, ain=1, sub=0; next T2.
  - 011 sub: rout[X]=1, ain=1, sub=1; next T2.
  - 100–111 undefined: done=1 only, no register written; next T0.
- T2, add/sub: rout[Y]=1, gin=1, sub=(opcode==011); next T3.
- T3: gout=1, rin[X]=1, done=1; next T0.
- Latency: mv/mvi/undefined take 2 cycles (T0+T1); add/sub take 4 cycles (T0..T3). done is high exactly 1 cycle per instruction.
- sub is held stable across T1 and T2 so the ALU sees a constant op while A and G load.
- run is ignored in T1–T3. A new instruction is accepted only on the cycle after done (T0). Back-to-back runs therefore issue one instruction per 2 or 4 cycles with no bubble.
- X==Y is legal:
  - mv R3,R3: rout[3] and rin[3] both asserted in the same cycle.
  - add R3,R3: doubles R3.
- At most one bit set in rin and at most one in rout in any cycle. At most one bus source active among rout, dinout, gout.
- Reset mid-instruction: state returns to T0 immediately and outputs drop the same instant. No partial rin write occurs after reset assertion.
- Unreachable state encodings are not possible with the 2-bit encoding: all 4 codes are defined.

Decomposition:
- Shared package/header simple_cpu_pkg holds:
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011;
  - state codes T0..T3;
  - DATA_W and IR_W defaults.
- The ALU and register-file blocks consume the same constants.
- One sub-module, dec3to8: 3-bit field to one-hot 8-bit with enable. It is instantiated twice, for X→rin/rout[X] and Y→rout[Y].

Test Plan:
- Reset during idle, then release with run=0 for 3 cycles -> state T0, all outputs 0, ir=0, irin=0.
- mvi R2 (din=9'b001_010_000, run=1) -> next cycle T1: dinout=1, rin=8'b00000100, done=1. Then back to T0.
- mv R5,R1 (din=9'b000_101_001) -> T1: rout=8'b00000010, rin=8'b00100000, done=1. Total 2 cycles.
- add R0,R1 (din=9'b010_000_001) -> check each state:
  - T1: rout=8'b00000001, ain=1, sub=0.
  - T2: rout=8'b00000010, gin=1, sub=0.
  - T3: gout=1, rin=8'b00000001, done=1.
  - With ALU attached, R0=100 and R1=50 give bus 150 in T3.
- sub R0,R1 (din=9'b011_000_001), R0=200, R1=25 -> sub=1 in T1 and T2; T3 gout=1 with ALU result 175, rin[0]=1, done=1.
- Robustness:
  - Toggle run during T2 -> ignored.
  - Assert reset in T2 of an add -> gin drops immediately, state=T0, no rin pulse.
  - Undefined opcode 9'b111_000_000 -> done in T1 only, rin=0.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : simple_cpu_pkg
// Brief  : Opcodes, timing-state codes and width defaults shared by the
//          control sequencer, ALU and register file.
// Rev    : 1.0
// ============================================================================
package simple_cpu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_IR_W   = 9;
    localparam int DEF_NREG   = 8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_control_fsm_dec3to8.sv
`default_nettype none
// ============================================================================
// Module : dec3to8
// Brief  : 3-bit register field to one-hot select, gated by an enable.
// Rev    : 1.0
// ============================================================================
module dec3to8 #(
    parameter int N = 8
) (
    input  logic         en_i,
    input  logic [2:0]   sel_i,
    output logic [N-1:0] onehot_o
);

    assign onehot_o = en_i ? (N'(1) << sel_i) : '0;

endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// Module : cpu_control_fsm
// Brief  : Instruction register and T0..T3 control sequencer for the ALU
//          datapath (mv, mvi, add, sub).
// Rev    : 1.0
// ============================================================================
module cpu_control_fsm
    import simple_cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IR_W   = DEF_IR_W,
    parameter int NREG   = DEF_NREG
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic              irin,
    output logic [NREG-1:0]   rin,
    output logic [NREG-1:0]   rout,
    output logic              dinout,
    output logic              gout,
    output logic              ain,
    output logic              gin,
    output logic              sub,
    output logic              done,
    output logic [IR_W-1:0]   ir
);

    state_t            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;

    logic [2:0]        w_op, w_x, w_y;
    logic              w_irin, w_rin_x, w_rout_x, w_rout_y;
    logic              w_dinout, w_gout, w_ain, w_gin, w_sub, w_done;
    logic [NREG-1:0]   w_x_oh, w_y_oh;
    logic              w_unused_din;

    assign w_op = ir_q[8:6];
    assign w_x  = ir_q[5:3];
    assign w_y  = ir_q[2:0];

    assign w_unused_din = ^din[DATA_W-1:IR_W];

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            T0: if (run) begin
                ir_d    = din[IR_W-1:0];
                state_d = T1;
            end
            T1: state_d = (w_op == OP_ADD || w_op == OP_SUB) ? T2 : T0;
            T2: state_d = T3;
            T3: state_d = T0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Control decode; sub stays at the opcode value across T1 and T2.
    always_comb begin
        w_irin   = 1'b0;
        w_rin_x  = 1'b0;
        w_rout_x = 1'b0;
        w_rout_y = 1'b0;
        w_dinout = 1'b0;
        w_gout   = 1'b0;
        w_ain    = 1'b0;
        w_gin    = 1'b0;
        w_sub    = 1'b0;
        w_done   = 1'b0;
        unique case (state_q)
            T0: w_irin = run;
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_rout_y = 1'b1;
                        w_rin_x  = 1'b1;
                        w_done   = 1'b1;
                    end
                    OP_MVI: begin
                        w_dinout = 1'b1;
                        w_rin_x  = 1'b1;
                        w_done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rout_x = 1'b1;
                        w_ain    = 1'b1;
                        w_sub    = (w_op == OP_SUB);
                    end
                    default: w_done = 1'b1;
                endcase
            end
            T2: begin
                w_rout_y = 1'b1;
                w_gin    = 1'b1;
                w_sub    = (w_op == OP_SUB);
            end
            T3: begin
                w_gout  = 1'b1;
                w_rin_x = 1'b1;
                w_done  = 1'b1;
            end
        endcase
    end

    dec3to8 #(.N(NREG)) u_dec_x (
        .en_i     (~reset),
        .sel_i    (w_x),
        .onehot_o (w_x_oh)
    );

    dec3to8 #(.N(NREG)) u_dec_y (
        .en_i     (~reset & w_rout_y),
        .sel_i    (w_y),
        .onehot_o (w_y_oh)
    );

    // Reset masks every strobe immediately, before the async state clear settles.
    assign irin   = w_irin   & ~reset;
    assign rin    = w_rin_x  ? w_x_oh : '0;
    assign rout   = (w_rout_x ? w_x_oh : '0) | w_y_oh;
    assign dinout = w_dinout & ~reset;
    assign gout   = w_gout   & ~reset;
    assign ain    = w_ain    & ~reset;
    assign gin    = w_gin    & ~reset;
    assign sub    = w_sub    & ~reset;
    assign done   = w_done   & ~reset;
    assign ir     = ir_q;

endmodule
`default_nettype wire
